// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master transfer port
// Issues trnsfr pulses, routes done/rdata back to the owner, and flags stalled transfers.
module apb_req_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_wr,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NREQ*2-1:0]          req_dsel,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       m_trnsfr,
  output logic                       m_wr,
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic [DATA_WIDTH-1:0]      m_data_in,
  output logic [1:0]                 m_dsel,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pready,
  input  logic [DATA_WIDTH-1:0]      m_data_out,
  output logic                       timeout,
  output logic                       busy
);

  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDW-1:0] WD_SAT  = WDW'(TIMEOUT);

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  arb_state_t      r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_rr_ptr;
  logic [WDW-1:0]  r_wd;

  logic            w_completion;
  logic            w_busy;
  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_eligible;
  logic            w_win_valid;
  logic [OW-1:0]   w_win_idx;
  logic            w_issue;
  logic            w_done_now;
  logic            w_sel_valid;
  logic [OW-1:0]   w_sel_idx;

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return OW'(s);
  endfunction

  assign w_completion = psel & penable & pready;
  assign w_busy       = (r_state == ARB_BUSY);
  assign w_owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  // While busy, a new winner may only be chosen in the completion cycle (back-to-back issue).
  always_comb begin
    w_eligible = '0;
    if (r_state == ARB_IDLE)
      w_eligible = req;
    else if (w_completion)
      w_eligible = req & ~w_owner_oh;
  end

  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_win_valid && w_eligible[wrap_idx(r_rr_ptr, k)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_issue     = rst_n & w_win_valid;
  assign w_done_now  = rst_n & w_busy & w_completion;
  assign w_sel_valid = rst_n & (w_issue | w_busy);
  assign w_sel_idx   = w_issue ? w_win_idx : r_owner;

  assign m_trnsfr  = w_issue;
  assign gnt       = w_issue ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win_idx) : '0;
  assign m_wr      = w_sel_valid & req_wr[w_sel_idx];
  assign m_address = w_sel_valid ? req_addr[w_sel_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign m_data_in = w_sel_valid ? req_wdata[w_sel_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_dsel    = w_sel_valid ? req_dsel[w_sel_idx*2 +: 2] : 2'b00;

  assign done    = w_done_now ? w_owner_oh : '0;
  assign rdata   = (w_done_now && !req_wr[r_owner]) ? m_data_out : '0;
  assign busy    = rst_n & w_busy;
  assign timeout = (TIMEOUT > 0) & rst_n & w_busy & ~w_completion & (r_wd == WD_LAST);

  // The watchdog saturates one past its trigger value so the pulse fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= OW'(NREQ - 1);
      r_wd     <= '0;
    end else if (w_issue) begin
      r_state  <= ARB_BUSY;
      r_owner  <= w_win_idx;
      r_rr_ptr <= w_win_idx;
      r_wd     <= '0;
    end else if (r_state == ARB_BUSY) begin
      if (w_completion) begin
        r_state <= ARB_IDLE;
        r_wd    <= '0;
      end else if (TIMEOUT > 0 && r_wd != WD_SAT) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master user-side transfer port (trnsfr/wr/address/data_in/dsel in; ready/data_out back) among NREQ local requesters using round-robin arbitration.
- Issues one single-cycle trnsfr pulse per granted request, tracks APB completion, and routes done/rdata back to the owner.
- Supports back-to-back issue in the completion cycle, so the master goes ACCESS->SETUP with no IDLE bubble.
- Includes a watchdog that flags stalled transfers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width; matches master address port.
- DATA_WIDTH, 32, data width; matches master data_in/data_out.
- TIMEOUT, 256, BUSY cycles without completion before the timeout flag; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- req  in  NREQ  per-requester request level.
- req_wr  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*ADDR_WIDTH  byte address, slice i = requester i.
- req_wdata  in  NREQ*DATA_WIDTH  right-aligned write data.
- req_dsel  in  NREQ*2  size: 0=word, 1=half, 2=byte.
- gnt  out  NREQ  one-hot, high only in the issue cycle.
- done  out  NREQ  one-hot, high in the APB completion cycle.
- rdata  out  DATA_WIDTH  read data, valid with done; 0 otherwise.
- m_trnsfr  out  1  transfer pulse to master.
- m_wr / m_address / m_data_in / m_dsel  out  1/ADDR_WIDTH/DATA_WIDTH/2  winner fields, muxed.
- psel / penable / pready  in  1/1/1  APB bus monitor.
- m_data_out  in  DATA_WIDTH  master's aligned read data.
- timeout  out  1  one-cycle pulse on watchdog expiry.
- busy  out  1  transfer in flight.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- State: ARB_IDLE, ARB_BUSY. Registers: owner index, rr_ptr (last granted), wd counter.
- Reset:
  - state=ARB_IDLE, rr_ptr=NREQ-1 (req0 wins first), wd=0.
  - All outputs 0, combinational ones included; they are gated by rst_n.
  - Reset mid-transfer: drop the owner, no done, no timeout. The master shares rst_n.
- completion = psel & penable & pready.
- Arbitration (combinational): scan eligible requesters starting at rr_ptr+1 modulo NREQ; first hit wins.
  - In ARB_IDLE, eligible = req.
  - In ARB_BUSY, eligible = req & ~onehot(owner).
- ARB_IDLE with any eligible request:
  - Same cycle: m_trnsfr=1, gnt[w]=1, m_* = slices of winner w.
  - At the clock edge: owner<=w, rr_ptr<=w, go to ARB_BUSY, wd<=0.
  - No requests: all m_* = 0.
- ARB_BUSY: m_trnsfr=0, m_* hold the owner's fields (the master latches only on trnsfr). busy=1.
- ARB_BUSY with completion:
  - done[owner]=1 and rdata=m_data_out when the owner is a read; rdata=0 when it is a write.
  - Eligible request present: m_trnsfr=1, gnt[w]=1, m_* = winner slices in the same cycle. Owner<=w, rr_ptr<=w, stay in ARB_BUSY, wd<=0.
  - Otherwise go to ARB_IDLE.
- Requester rule: hold req and fields stable from assertion through done. A req still high on the cycle after done counts as a new request.
  - The arbiter does not check this rule.
  - Dropping req before done does not cancel the in-flight transfer.
- First-issue latency: gnt in the req cycle (comb). Master SETUP at +1, ACCESS at +2, earliest done at +2.
- Back-to-back sequence: completion and gnt coincide, the next SETUP follows at +1.
- Watchdog (TIMEOUT>0): wd increments each ARB_BUSY cycle without completion.
  - At wd==TIMEOUT-1 and still no completion: timeout pulses 1 cycle and wd saturates.
  - Informational only: the transfer is not aborted and the state is unchanged.
- Width rule: m_dsel passes through unchanged. Only 0/1/2 are legal; 3 is not checked.

Test Plan:
- Single read: req[0]=1, addr=0x0000_0010, dsel=0; slave pready=1 in first ACCESS with m_data_out=0xDEAD_BEEF -> gnt[0] in cycle 0, m_trnsfr pulse 1 cycle, done[0]=1 and rdata=0xDEAD_BEEF in cycle 2, then ARB_IDLE.
- Round-robin: req=4'b1111 held, zero-wait slave -> grant order 0,1,2,3,0; each new gnt coincides with the previous done (no IDLE cycle); psel stays high throughout.
- Wait states: req[2]=1 write, wdata=0x0000_00AB, dsel=2, addr=0x...3; pready low for 3 ACCESS cycles -> m_trnsfr high exactly once, m_* stable, done[2] only when pready=1, rdata=0.
- Owner masking: req[1] held high continuously with req[3]=1 -> after done[1], next gnt goes to 3, not 1; req[1] is granted after 3 completes.
- Watchdog: TIMEOUT=8, pready stuck at 0 -> timeout pulses once at BUSY cycle 8, busy stays 1; pready=1 later -> normal done.
- Reset mid-ACCESS: rst_n low during a wait-stated transfer -> all outputs 0 immediately, no done; after release with req=4'b0100, req2 is granted and rr_ptr restarts at NREQ-1.
